// File: rtl/gpr_access_ctrl.sv
// Command sequencer in front of the general purpose register file: issues one
// read-sum or write per command and returns the file's registered sum.
module gpr_access_ctrl #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [REG_W-1:0]  cmd_idx_a,
  input  logic [REG_W-1:0]  cmd_idx_b,
  input  logic [REG_W-1:0]  cmd_idx_c,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] gpr_address,
  output logic [DATA_W-1:0] gpr_data_in,
  output logic              gpr_rd,
  output logic              gpr_wr,
  input  logic [DATA_W-1:0] gpr_data_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic              op_q;
  logic              accept;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_valid & cmd_ready;

  // Read packs all three indices MSB-first; write uses only the low index bits.
  always_comb begin
    rd_addr = '0;
    rd_addr[ADDR_W-1 -: 3*REG_W] = {cmd_idx_a, cmd_idx_b, cmd_idx_c};
    wr_addr = '0;
    wr_addr[REG_W-1:0] = cmd_idx_a;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid) state_d = StIssue;
      StIssue: state_d = op_q ? StIdle : StWait;
      StWait:  state_d = StHold;
      StHold:  if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 1'b0;
      gpr_address <= '0;
      gpr_data_in <= '0;
      gpr_rd      <= 1'b0;
      gpr_wr      <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
    end else begin
      state_q <= state_d;
      // Strobes are single-cycle pulses, cleared every edge unless re-armed.
      gpr_rd  <= 1'b0;
      gpr_wr  <= 1'b0;
      if (accept) begin
        op_q <= cmd_op;
        if (cmd_op) begin
          gpr_wr      <= 1'b1;
          gpr_address <= wr_addr;
          gpr_data_in <= cmd_wdata;
        end else begin
          gpr_rd      <= 1'b1;
          gpr_address <= rd_addr;
        end
      end
      if (state_q == StWait) begin
        res_data  <= gpr_data_out;
        res_valid <= 1'b1;
      end
      if (state_q == StHold && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
